// File: rtl/instructions_pkg.sv
// Purpose : architectural register type shared across the core.
// Contents: arch_reg - 32-bit architectural word (addresses and data).
package instructions_pkg;

    typedef logic [31:0] arch_reg;

endpackage

// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and constants for the unified memory port arbiter.
// Contents: arb_state_e (arbiter FSM states), byte_en_t (4-bit byte enable),
//           FETCH_BE (instruction fetches always read the full word).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_e;

    typedef logic [3:0] byte_en_t;

    localparam byte_en_t FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between instruction fetch and the
//           load/store unit. One transaction outstanding at a time; data has
//           priority, bounded by MAX_DATA_BURST so fetch always progresses.
//           Fetch responses overtaken by a PC redirect are dropped.
// Ports   : clock, reset (async, active-high)
//           if_*  : fetch request/flush in, if_valid/if_rdata/if_stall out
//           ls_*  : load/store request in, ls_done/ls_rdata out
//           mem_* : registered request fields out, mem_ready/mem_rdata in
//
// state     | meaning
// ARB_IDLE  | no transaction; arbitrate between ls_req and if_req
// ARB_FETCH | fetch transaction outstanding, waiting for mem_ready
// ARB_DATA  | data transaction outstanding, waiting for mem_ready
module mem_port_arbiter
    import instructions_pkg::*;
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     if_req,
    input  arch_reg  if_addr,
    input  logic     if_flush,
    output logic     if_valid,
    output arch_reg  if_rdata,
    output logic     if_stall,
    input  logic     ls_req,
    input  logic     ls_we,
    input  byte_en_t ls_be,
    input  arch_reg  ls_addr,
    input  arch_reg  ls_wdata,
    output logic     ls_done,
    output arch_reg  ls_rdata,
    output logic     mem_req,
    output logic     mem_we,
    output byte_en_t mem_be,
    output arch_reg  mem_addr,
    output arch_reg  mem_wdata,
    input  logic     mem_ready,
    input  arch_reg  mem_rdata
);

    localparam int BW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

    arb_state_e      r_state;
    logic            r_kill;
    logic [BW-1:0]   r_burst_cnt;
    logic            r_mem_we;
    byte_en_t        r_mem_be;
    arch_reg         r_mem_addr;
    arch_reg         r_mem_wdata;

    logic            w_idle;
    logic            w_grant_data;
    logic            w_grant_fetch;
    logic            w_fetch_done;
    logic            w_data_done;

    assign w_idle        = (r_state == ARB_IDLE);
    // Data wins unless fetch is waiting and the burst allowance is used up.
    assign w_grant_data  = w_idle & ls_req & (~if_req | (r_burst_cnt < BURST_MAX));
    assign w_grant_fetch = w_idle & ~w_grant_data & if_req & ~if_flush;
    assign w_fetch_done  = (r_state == ARB_FETCH) & mem_ready;
    assign w_data_done   = (r_state == ARB_DATA) & mem_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_kill      <= 1'b0;
            r_burst_cnt <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_data) begin
                        r_state     <= ARB_DATA;
                        r_mem_we    <= ls_we;
                        r_mem_be    <= ls_be;
                        r_mem_addr  <= ls_addr;
                        r_mem_wdata <= ls_wdata;
                        // Only grants that make fetch wait count toward the burst.
                        if (!if_req) begin
                            r_burst_cnt <= '0;
                        end else if (r_burst_cnt != BURST_MAX) begin
                            r_burst_cnt <= r_burst_cnt + BW'(1);
                        end
                    end else if (w_grant_fetch) begin
                        r_state     <= ARB_FETCH;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= FETCH_BE;
                        r_mem_addr  <= if_addr;
                        r_burst_cnt <= '0;
                    end
                end
                ARB_FETCH: begin
                    // The transaction is never aborted; a redirect only marks
                    // its response for discard.
                    if (mem_ready) begin
                        r_state <= ARB_IDLE;
                        r_kill  <= 1'b0;
                    end else if (if_flush) begin
                        r_kill  <= 1'b1;
                    end
                end
                ARB_DATA: begin
                    if (mem_ready) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = ~w_idle;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // A flush coinciding with mem_ready also discards the response.
    assign if_valid  = w_fetch_done & ~r_kill & ~if_flush;
    assign if_rdata  = if_valid ? mem_rdata : '0;
    assign if_stall  = if_req & ~if_valid;

    assign ls_done   = w_data_done;
    assign ls_rdata  = w_data_done ? mem_rdata : '0;

endmodule
